hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. It sits beside the decode/execute pipeline registers and generates:
- forwarding selects for the execute-stage ALU operands;
- load-use stalls and branch/jump flushes;
- whole-pipeline stalls while data memory is not ready.

A wait-cycle watchdog moves the core into a sticky halted error state when a memory access never completes.

---
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the RV32I pipeline and its hazard controller.
// The master side is the pipeline; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemErr;
  logic [31:0] StallCount, FlushCount;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use/branch/memory stalls and flushes,
// memory-wait watchdog. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // ERR is taken on the edge that completes the TIMEOUT-th consecutive wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d, state_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall, mem_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && rd_m != 5'd0 && rd_m == rs)
      sel = 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs)
      sel = 2'b01;
    return sel;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.rs1E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);
  assign hz.ForwardBE = fwd_sel(hz.rs2E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);

  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.rdE != 5'd0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
  assign mem_stall = hz.MemReqM && !hz.MemReadyM;

  // While reset is held the outputs behave as in RUN, whatever the stored state.
  assign state_eff = RST ? RUN : state_q;

  always_comb begin
    hz.StallF = lw_stall;
    hz.StallD = lw_stall;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = hz.PCSrcE;
    hz.FlushE = lw_stall || hz.PCSrcE;
    hz.FlushW = 1'b0;
    hz.MemErr = 1'b0;
    if (state_eff == ERR || mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
      hz.MemErr = (state_eff == ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          if (TIMEOUT == 1) begin
            state_d = ERR;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallF && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (hz.PCSrcE && hz.FlushD && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = '0;
  assign hz.FlushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with TIMEOUT=4 (watchdog),
// one with TIMEOUT=64 (ordinary memory waits), driven with identical inputs.
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic       CLK, RST;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;
  int         n_checks, n_fails;

  hazard_ctrl_if hz4 ();
  hazard_ctrl_if hz64 ();

  assign hz4.rs1D = rs1D;        assign hz64.rs1D = rs1D;
  assign hz4.rs2D = rs2D;        assign hz64.rs2D = rs2D;
  assign hz4.rs1E = rs1E;        assign hz64.rs1E = rs1E;
  assign hz4.rs2E = rs2E;        assign hz64.rs2E = rs2E;
  assign hz4.rdE = rdE;          assign hz64.rdE = rdE;
  assign hz4.rdM = rdM;          assign hz64.rdM = rdM;
  assign hz4.rdW = rdW;          assign hz64.rdW = rdW;
  assign hz4.RegWriteM = RegWriteM;   assign hz64.RegWriteM = RegWriteM;
  assign hz4.RegWriteW = RegWriteW;   assign hz64.RegWriteW = RegWriteW;
  assign hz4.ResultSrcE = ResultSrcE; assign hz64.ResultSrcE = ResultSrcE;
  assign hz4.PCSrcE = PCSrcE;         assign hz64.PCSrcE = PCSrcE;
  assign hz4.MemReqM = MemReqM;       assign hz64.MemReqM = MemReqM;
  assign hz4.MemReadyM = MemReadyM;   assign hz64.MemReadyM = MemReadyM;

  hazard_ctrl #(.TIMEOUT(4),  .CNT_W(7)) u_dut4  (.CLK(CLK), .RST(RST), .hz(hz4));
  hazard_ctrl #(.TIMEOUT(64), .CNT_W(7)) u_dut64 (.CLK(CLK), .RST(RST), .hz(hz64));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s = %0h", $time, tag, got);
    end
  endtask

  task automatic idle();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    RST = 1'b1;
    idle();

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("rst_fwdA",     32'(hz4.ForwardAE), 32'd0);
    check("rst_stallF",   32'(hz4.StallF), 32'd0);
    check("rst_memerr",   32'(hz4.MemErr), 32'd0);
    check("rst_stallcnt", hz4.StallCount, 32'd0);
    check("rst_flushcnt", hz4.FlushCount, 32'd0);

    // Forwarding (combinational, settled before the next rising edge)
    @(negedge CLK);
    RST = 1'b0;
    rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1; rs1E = 5'd5; rs2E = 5'd5;
    #1;
    check("fwdA_mem", 32'(hz4.ForwardAE), 32'd2);
    check("fwdB_mem", 32'(hz4.ForwardBE), 32'd2);
    rdM = 5'd0;
    #1;
    check("fwdA_wb", 32'(hz4.ForwardAE), 32'd1);
    check("fwdB_wb", 32'(hz4.ForwardBE), 32'd1);
    rs1E = 5'd0;
    #1;
    check("fwdA_x0", 32'(hz4.ForwardAE), 32'd0);
    check("fwdB_wb2", 32'(hz4.ForwardBE), 32'd1);
    idle();

    // Load-use
    @(negedge CLK);
    ResultSrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
    #1;
    check("lw_stallF", 32'(hz4.StallF), 32'd1);
    check("lw_stallD", 32'(hz4.StallD), 32'd1);
    check("lw_flushE", 32'(hz4.FlushE), 32'd1);
    check("lw_flushD", 32'(hz4.FlushD), 32'd0);
    check("lw_stallE", 32'(hz4.StallE), 32'd0);
    rdE = 5'd0;
    #1;
    check("lw_x0_stallF", 32'(hz4.StallF), 32'd0);
    check("lw_x0_flushE", 32'(hz4.FlushE), 32'd0);
    idle();

    // Branch
    @(negedge CLK);
    PCSrcE = 1'b1;
    #1;
    check("br_flushD", 32'(hz4.FlushD), 32'd1);
    check("br_flushE", 32'(hz4.FlushE), 32'd1);
    check("br_stallF", 32'(hz4.StallF), 32'd0);
    idle();

    // Branch deferred behind a memory wait
    @(negedge CLK);
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    #1;
    check("def_flushD", 32'(hz4.FlushD), 32'd0);
    check("def_flushE", 32'(hz4.FlushE), 32'd0);
    check("def_stallE", 32'(hz4.StallE), 32'd1);
    check("def_flushW", 32'(hz4.FlushW), 32'd1);
    @(negedge CLK);
    MemReadyM = 1'b1;
    #1;
    check("rel_flushD", 32'(hz4.FlushD), 32'd1);
    check("rel_flushE", 32'(hz4.FlushE), 32'd1);
    check("rel_stallF", 32'(hz4.StallF), 32'd0);
    @(negedge CLK);
    idle();
    #1;
    check("def_stallcnt", hz4.StallCount, (PERF != 0) ? 32'd1 : 32'd0);
    check("def_flushcnt", hz4.FlushCount, (PERF != 0) ? 32'd1 : 32'd0);

    // Memory wait of three cycles on TIMEOUT=64
    @(negedge CLK);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    check("mw_ready_now", 32'(hz64.StallF), 32'd0);
    MemReadyM = 1'b0;
    #1;
    check("mw_c1_stallF", 32'(hz64.StallF), 32'd1);
    check("mw_c1_flushW", 32'(hz64.FlushW), 32'd1);
    @(negedge CLK);
    #1;
    check("mw_c2_stallM", 32'(hz64.StallM), 32'd1);
    @(negedge CLK);
    #1;
    check("mw_c3_stallD", 32'(hz64.StallD), 32'd1);
    @(negedge CLK);
    MemReadyM = 1'b1;
    #1;
    check("mw_done_stallF", 32'(hz64.StallF), 32'd0);
    check("mw_done_flushW", 32'(hz64.FlushW), 32'd0);
    check("mw_done_err4",   32'(hz4.MemErr), 32'd0);
    @(negedge CLK);
    idle();
    #1;
    check("mw_memerr64", 32'(hz64.MemErr), 32'd0);
    check("mw_stallE64", 32'(hz64.StallE), 32'd0);
    check("mw_stallcnt", hz64.StallCount, (PERF != 0) ? 32'd4 : 32'd0);

    // Watchdog on TIMEOUT=4
    @(negedge CLK);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("wd_before", 32'(hz4.MemErr), 32'd0);
    @(negedge CLK);
    #1;
    check("wd_err",      32'(hz4.MemErr), 32'd1);
    check("wd_err64",    32'(hz64.MemErr), 32'd0);
    MemReadyM = 1'b1;
    #1;
    check("wd_hold_stallF",   32'(hz4.StallF), 32'd1);
    check("wd_hold_stallF64", 32'(hz64.StallF), 32'd0);
    @(negedge CLK);
    #1;
    check("wd_sticky",   32'(hz4.MemErr), 32'd1);
    check("wd_stallcnt", hz4.StallCount, (PERF != 0) ? 32'd9 : 32'd0);
    RST = 1'b1;
    #1;
    check("wd_rst_memerr", 32'(hz4.MemErr), 32'd0);
    check("wd_rst_stallF", 32'(hz4.StallF), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle();
    #1;
    check("wd_clr_memerr",   32'(hz4.MemErr), 32'd0);
    check("wd_clr_stallcnt", hz4.StallCount, 32'd0);
    check("wd_clr_flushcnt", hz4.FlushCount, 32'd0);
    @(negedge CLK);
    #1;
    check("wd_run_memerr", 32'(hz4.MemErr), 32'd0);
    check("wd_run_stallF", 32'(hz4.StallF), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
